// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM encoding, address field layout, defaults.
// Pure declarations, no logic.
package sdram_pkg;

    localparam int ADR_W           = 24;
    localparam int DATA_W          = 16;
    localparam int TIMEOUT_DEFAULT = 1023;

    // Address layout {bank, row, col}
    localparam int BANK_HI = 23;
    localparam int BANK_LO = 22;
    localparam int ROW_HI  = 21;
    localparam int ROW_LO  = 9;
    localparam int COL_HI  = 8;
    localparam int COL_LO  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Request captured at grant time and replayed to the controller
    typedef struct packed {
        logic              we;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdata;
    } hold_t;

    function automatic logic [1:0] adr_bank(input logic [ADR_W-1:0] adr);
        return adr[BANK_HI:BANK_LO];
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the two client ports plus the controller trigger/busy side of the arbiter.
// master = arbiter view, slave = clients and controller view.
interface sdram_port_arbiter_if;
    import sdram_pkg::*;

    logic              P0_REQ, P1_REQ;
    logic              P0_WE, P1_WE;
    logic [ADR_W-1:0]  P0_ADR, P1_ADR;
    logic [DATA_W-1:0] P0_WDATA, P1_WDATA;
    logic              P0_ACK, P1_ACK;
    logic [DATA_W-1:0] P0_RDATA, P1_RDATA;
    logic              P0_ERR, P1_ERR;

    logic              RD_TRIG, WT_TRIG;
    logic [ADR_W-1:0]  RD_ADR, WT_ADR;
    logic [DATA_W-1:0] WT_DATA;
    logic              RD_BUSY, WT_BUSY;
    logic [DATA_W-1:0] RD_DATA;

    modport master (
        input  P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADR, P1_ADR, P0_WDATA, P1_WDATA,
        input  RD_BUSY, WT_BUSY, RD_DATA,
        output P0_ACK, P1_ACK, P0_RDATA, P1_RDATA, P0_ERR, P1_ERR,
        output RD_TRIG, WT_TRIG, RD_ADR, WT_ADR, WT_DATA
    );

    modport slave (
        output P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADR, P1_ADR, P0_WDATA, P1_WDATA,
        output RD_BUSY, WT_BUSY, RD_DATA,
        input  P0_ACK, P1_ACK, P0_RDATA, P1_RDATA, P0_ERR, P1_ERR,
        input  RD_TRIG, WT_TRIG, RD_ADR, WT_ADR, WT_DATA
    );

endinterface

// File: rtl/rr_grant2.sv
// Two-way round-robin grant, combinational (zero latency); the port not granted last wins a tie.
// No backpressure: a grant is produced whenever any request is present.
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin front end for an SDRAM controller; >=4 cycles per transaction plus controller busy time.
// Clients hold REQ until ACK/ERR; the trigger is held until the controller raises BUSY or TIMEOUT expires.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    sdram_port_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    logic [1:0]        req, grant, err_q;
    logic              gnt_q, last_q;
    logic              busy_sel, timeout_hit, can_grant;
    hold_t             hold_q;
    logic [15:0]       cnt_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign req         = {bus.P1_REQ, bus.P0_REQ};
    assign busy_sel    = hold_q.we ? bus.WT_BUSY : bus.RD_BUSY;
    assign timeout_hit = (cnt_q + 16'd1) == 16'(TIMEOUT);
    // The cycle carrying ERR must not re-grant, same as the DONE cycle carrying ACK
    assign can_grant   = (grant != 2'b00) && (err_q == 2'b00);

    rr_grant2 u_rr_grant2 (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_grant) state_d = ISSUE;
            ISSUE: begin
                if (busy_sel) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT:    if (!busy_sel) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.RD_TRIG = 1'b0;
        bus.WT_TRIG = 1'b0;
        bus.RD_ADR  = '0;
        bus.WT_ADR  = '0;
        bus.WT_DATA = '0;
        bus.P0_ACK  = 1'b0;
        bus.P1_ACK  = 1'b0;
        if (state_q == ISSUE) begin
            if (hold_q.we) begin
                bus.WT_TRIG = 1'b1;
                bus.WT_ADR  = hold_q.adr;
                bus.WT_DATA = hold_q.wdata;
            end else begin
                bus.RD_TRIG = 1'b1;
                bus.RD_ADR  = hold_q.adr;
            end
        end
        if (state_q == DONE) begin
            bus.P0_ACK = !gnt_q;
            bus.P1_ACK = gnt_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            hold_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            err_q <= 2'b00;
            if (state_q == IDLE && can_grant) begin
                gnt_q  <= grant[1];
                last_q <= grant[1];
                hold_q <= grant[1] ? {bus.P1_WE, bus.P1_ADR, bus.P1_WDATA}
                                   : {bus.P0_WE, bus.P0_ADR, bus.P0_WDATA};
                cnt_q  <= '0;
            end
            if (state_q == ISSUE) begin
                cnt_q <= cnt_q + 16'd1;
                if (!busy_sel && timeout_hit) begin
                    err_q <= gnt_q ? 2'b10 : 2'b01;
                end
            end
            // Read data is captured on the same edge that raises ACK
            if (state_q == WAIT && !busy_sel && !hold_q.we) begin
                if (gnt_q) begin
                    rdata1_q <= bus.RD_DATA;
                end else begin
                    rdata0_q <= bus.RD_DATA;
                end
            end
        end
    end

    assign bus.P0_ERR   = err_q[0];
    assign bus.P1_ERR   = err_q[1];
    assign bus.P0_RDATA = rdata0_q;
    assign bus.P1_RDATA = rdata1_q;

endmodule
